// File: rtl/ccd_pkg.sv
// ccd_pkg: shared constants and state encoding for the CCD line capture path.
//   PIX_N_DEF / PIX_W_DEF / SKIP_N_DEF : default line geometry
//   SPEC_W                             : packed line width, also used by UART_TX_Sequence
//   CNT_W / SKIP_W                     : pixel and skip counter widths
//   state_t                            : capture FSM states
package ccd_pkg;
    localparam int PIX_N_DEF  = 370;
    localparam int PIX_W_DEF  = 10;
    localparam int SKIP_N_DEF = 32;
    localparam int SPEC_W     = PIX_N_DEF * PIX_W_DEF;
    localparam int CNT_W      = 9;
    localparam int SKIP_W     = 6;
    typedef enum logic [1:0] {IDLE, SKIP, CAPTURE, DONE} state_t;
endpackage

// File: rtl/ccd_pixel_counter.sv
// ccd_pixel_counter: combined dummy-pixel skip counter and active-pixel counter.
//   clk_50m, rst_n     : clock, asynchronous active-low reset
//   clr_i              : clear both counters (held while the capture FSM is idle)
//   skip_inc_i         : count one skipped sample
//   pix_inc_i          : count one stored sample
//   pix_cnt_o          : index of the next slice to write
//   skip_tc_o          : current strobe is the last dummy pixel
//   pix_tc_o           : current strobe is the last active pixel
module ccd_pixel_counter
    import ccd_pkg::*;
#(
    parameter int PIX_N  = PIX_N_DEF,
    parameter int SKIP_N = SKIP_N_DEF
) (
    input  logic             clk_50m,
    input  logic             rst_n,
    input  logic             clr_i,
    input  logic             skip_inc_i,
    input  logic             pix_inc_i,
    output logic [CNT_W-1:0] pix_cnt_o,
    output logic             skip_tc_o,
    output logic             pix_tc_o
);
    logic [SKIP_W-1:0] skip_q, skip_d;
    logic [CNT_W-1:0]  pix_q, pix_d;

    always_comb begin
        skip_d = clr_i ? '0 : skip_inc_i ? skip_q + 1'b1 : skip_q;
        pix_d  = clr_i ? '0 : pix_inc_i  ? pix_q + 1'b1  : pix_q;
    end

    always_ff @(posedge clk_50m or negedge rst_n) begin
        if (!rst_n) begin
            skip_q <= '0;
            pix_q  <= '0;
        end else begin
            skip_q <= skip_d;
            pix_q  <= pix_d;
        end
    end

    // With SKIP_N == 0 the SKIP state is never entered, so the flag is tied off.
    assign skip_tc_o = (SKIP_N > 0) && (skip_q == SKIP_W'(SKIP_N - 1));
    assign pix_tc_o  = pix_q == CNT_W'(PIX_N - 1);
    assign pix_cnt_o = pix_q;
endmodule

// File: rtl/ccd_spectrum_capture.sv
// ccd_spectrum_capture: captures one CCD line into the packed spectrum vector and pulses start.
//   clk_50m, rst_n   : 50 MHz clock, asynchronous active-low reset
//   arm              : level, request capture of the next line (sampled in IDLE only)
//   tx_busy          : downstream transmitter busy; blocks line start
//   frame_sync       : line start pulse; aborts a line in progress
//   adc_valid        : sample strobe for adc_data
//   adc_data         : pixel sample
//   spectrum_values  : packed line, pixel k at [k*PIX_W +: PIX_W]
//   start            : one-cycle pulse when a full line is present
//   busy             : high while skipping or capturing
//   short_frame      : sticky truncated-line flag, cleared by the next start
module ccd_spectrum_capture
    import ccd_pkg::*;
#(
    parameter int PIX_N  = PIX_N_DEF,
    parameter int PIX_W  = PIX_W_DEF,
    parameter int SKIP_N = SKIP_N_DEF
) (
    input  logic                   clk_50m,
    input  logic                   rst_n,
    input  logic                   arm,
    input  logic                   tx_busy,
    input  logic                   frame_sync,
    input  logic                   adc_valid,
    input  logic [PIX_W-1:0]       adc_data,
    output logic [PIX_N*PIX_W-1:0] spectrum_values,
    output logic                   start,
    output logic                   busy,
    output logic                   short_frame
);
    state_t                 state_q;
    logic [PIX_N*PIX_W-1:0] spec_q;
    logic                   start_q, busy_q, short_q;
    logic                   take, cnt_clr, skip_inc, pix_inc, skip_tc, pix_tc;
    logic [CNT_W-1:0]       pix_cnt;

    // A sample coinciding with frame_sync belongs to an aborted line and is dropped.
    always_comb begin
        take     = adc_valid && !frame_sync;
        cnt_clr  = state_q == IDLE;
        skip_inc = (state_q == SKIP) && take;
        pix_inc  = (state_q == CAPTURE) && take;
    end

    ccd_pixel_counter #(
        .PIX_N (PIX_N),
        .SKIP_N(SKIP_N)
    ) u_cnt (
        .clk_50m   (clk_50m),
        .rst_n     (rst_n),
        .clr_i     (cnt_clr),
        .skip_inc_i(skip_inc),
        .pix_inc_i (pix_inc),
        .pix_cnt_o (pix_cnt),
        .skip_tc_o (skip_tc),
        .pix_tc_o  (pix_tc)
    );

    always_ff @(posedge clk_50m or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            spec_q  <= '0;
            start_q <= 1'b0;
            busy_q  <= 1'b0;
            short_q <= 1'b0;
        end else begin
            start_q <= 1'b0;
            case (state_q)
                IDLE:
                    if (frame_sync && arm && !tx_busy) begin
                        state_q <= (SKIP_N > 0) ? SKIP : CAPTURE;
                        busy_q  <= 1'b1;
                    end
                SKIP, CAPTURE:
                    if (frame_sync) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                        short_q <= 1'b1;
                    end else if (skip_inc && skip_tc) begin
                        state_q <= CAPTURE;
                    end else if (pix_inc) begin
                        spec_q[int'(pix_cnt)*PIX_W +: PIX_W] <= adc_data;
                        // start and the cleared error flag appear together with DONE.
                        if (pix_tc) begin
                            state_q <= DONE;
                            busy_q  <= 1'b0;
                            start_q <= 1'b1;
                            short_q <= 1'b0;
                        end
                    end
                DONE:    state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    assign spectrum_values = spec_q;
    assign start           = start_q;
    assign busy            = busy_q;
    assign short_frame     = short_q;
endmodule

// File: tb/tb_ccd_spectrum_capture.sv
// tb_ccd_spectrum_capture: directed/randomized bench with a line-level reference model.
module tb_ccd_spectrum_capture;
    localparam int PIX_N  = 370;
    localparam int PIX_W  = 10;
    localparam int SKIP_N = 32;
    localparam int SW     = PIX_N * PIX_W;
    localparam int LINE   = SKIP_N + PIX_N;

    logic             clk_50m = 1'b0;
    logic             rst_n = 1'b0;
    logic             arm = 1'b0;
    logic             tx_busy = 1'b0;
    logic             frame_sync = 1'b0;
    logic             adc_valid = 1'b0;
    logic [PIX_W-1:0] adc_data = '0;
    logic [SW-1:0]    spectrum_values;
    logic             start, busy, short_frame;

    int checks = 0;
    int errors = 0;
    int model[PIX_N];
    int vals[$];
    int start_tot = 0;
    int busy_tot = 0;

    ccd_spectrum_capture dut (
        .clk_50m        (clk_50m),
        .rst_n          (rst_n),
        .arm            (arm),
        .tx_busy        (tx_busy),
        .frame_sync     (frame_sync),
        .adc_valid      (adc_valid),
        .adc_data       (adc_data),
        .spectrum_values(spectrum_values),
        .start          (start),
        .busy           (busy),
        .short_frame    (short_frame)
    );

    always #10 clk_50m = ~clk_50m;

    always @(negedge clk_50m) begin
        start_tot += (start === 1'b1) ? 1 : 0;
        busy_tot  += (busy === 1'b1) ? 1 : 0;
    end

    task automatic tick();
        @(posedge clk_50m);
        #1;
    endtask

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic logic [SW-1:0] packed_model();
        logic [SW-1:0] v;
        for (int k = 0; k < PIX_N; k++) v[k*PIX_W +: PIX_W] = PIX_W'(model[k]);
        return v;
    endfunction

    task automatic chk_spec(string tag);
        logic [SW-1:0] e;
        int bad;
        e = packed_model();
        bad = 0;
        for (int k = PIX_N - 1; k >= 0; k--)
            if (spectrum_values[k*PIX_W +: PIX_W] !== e[k*PIX_W +: PIX_W]) bad = k;
        checks++;
        assert (spectrum_values === e) else begin
            errors++;
            $error("FAIL %s: slice %0d observed %0d expected %0d", tag, bad,
                   spectrum_values[bad*PIX_W +: PIX_W], e[bad*PIX_W +: PIX_W]);
        end
    endtask

    // An accepted line stores the strobes that follow the first SKIP_N dummies.
    task automatic commit(int n_active);
        for (int k = 0; k < n_active; k++) model[k] = vals[SKIP_N + k];
    endtask

    task automatic sync(bit with_valid, logic [PIX_W-1:0] d);
        frame_sync = 1'b1;
        adc_valid  = with_valid;
        adc_data   = d;
        tick();
        frame_sync = 1'b0;
        adc_valid  = 1'b0;
    endtask

    task automatic feed(int n, int gap, bit seq, output bit start_at_last);
        int v;
        start_at_last = 1'b0;
        for (int i = 0; i < n; i++) begin
            repeat (gap) tick();
            v = seq ? i : int'($urandom_range(0, 1023));
            vals.push_back(v);
            adc_valid = 1'b1;
            adc_data  = PIX_W'(v);
            tick();
            adc_valid = 1'b0;
            if (i == n - 1) start_at_last = start;
        end
    endtask

    task automatic full_line(string tag, int gap, bit seq);
        int s0, b0;
        bit sl;
        vals.delete();
        s0 = start_tot;
        b0 = busy_tot;
        sync(1'b1, 10'h3e7);
        feed(LINE, gap, seq, sl);
        commit(PIX_N);
        chk({tag, " start after last strobe"}, 32'(sl), 1);
        tick();
        chk({tag, " start pulses"}, start_tot - s0, 1);
        chk({tag, " busy width"}, busy_tot - b0, LINE * (gap + 1));
        chk({tag, " short_frame"}, 32'(short_frame), 0);
        chk({tag, " busy idle"}, 32'(busy), 0);
        chk_spec({tag, " spectrum"});
    endtask

    task automatic ignored_line(string tag);
        int s0, b0;
        bit sl;
        s0 = start_tot;
        b0 = busy_tot;
        sync(1'b0, '0);
        feed(LINE, 0, 1'b0, sl);
        tick();
        chk({tag, " busy never rose"}, busy_tot - b0, 0);
        chk({tag, " no start"}, start_tot - s0, 0);
        chk_spec({tag, " spectrum unchanged"});
    endtask

    initial begin
        int s0, b0;
        bit sl;
        for (int k = 0; k < PIX_N; k++) model[k] = 0;
        repeat (3) tick();
        chk_spec("reset spectrum");
        chk("reset start", 32'(start), 0);
        chk("reset busy", 32'(busy), 0);
        chk("reset short_frame", 32'(short_frame), 0);
        rst_n = 1'b1;
        arm   = 1'b1;
        tick();

        full_line("nominal", 0, 1'b1);
        chk("nominal slice0", 32'(spectrum_values[0 +: PIX_W]), 32);
        chk("nominal slice369", 32'(spectrum_values[369*PIX_W +: PIX_W]), 401);
        full_line("sparse", 6, 1'b1);
        full_line("random", int'($urandom_range(0, 2)), 1'b0);

        // Truncated line; the abort cycle carries a sample that must be dropped.
        vals.delete();
        s0 = start_tot;
        sync(1'b0, '0);
        feed(SKIP_N + 100, 0, 1'b0, sl);
        commit(100);
        sync(1'b1, 10'h155);
        chk("trunc short_frame", 32'(short_frame), 1);
        chk("trunc busy", 32'(busy), 0);
        chk("trunc no start", start_tot - s0, 0);
        chk_spec("trunc spectrum");
        b0 = busy_tot;
        feed(40, 0, 1'b0, sl);
        chk("trunc no restart", busy_tot - b0, 0);
        chk_spec("trunc no restart spectrum");
        full_line("after trunc", 1, 1'b0);

        tx_busy = 1'b1;
        ignored_line("tx_busy sync");
        tx_busy = 1'b0;
        full_line("after tx_busy", 0, 1'b0);

        arm = 1'b0;
        ignored_line("arm low sync");
        arm = 1'b1;

        // arm dropped and tx_busy raised mid-capture: line still completes.
        vals.delete();
        s0 = start_tot;
        sync(1'b0, '0);
        feed(SKIP_N + 150, 1, 1'b0, sl);
        arm     = 1'b0;
        tx_busy = 1'b1;
        feed(PIX_N - 150, 0, 1'b0, sl);
        commit(PIX_N);
        chk("arm drop start latency", 32'(sl), 1);
        tick();
        chk("arm drop start pulses", start_tot - s0, 1);
        chk_spec("arm drop spectrum");
        arm     = 1'b1;
        tx_busy = 1'b0;

        // Set short_frame, then reset in the middle of the following line.
        sync(1'b0, '0);
        feed(SKIP_N + 10, 0, 1'b0, sl);
        sync(1'b0, '0);
        chk("pre-reset short_frame", 32'(short_frame), 1);
        sync(1'b0, '0);
        feed(SKIP_N + 200, 0, 1'b0, sl);
        chk("pre-reset busy", 32'(busy), 1);
        #3 rst_n = 1'b0;
        #1;
        for (int k = 0; k < PIX_N; k++) model[k] = 0;
        chk_spec("async reset spectrum");
        chk("async reset busy", 32'(busy), 0);
        chk("async reset short_frame", 32'(short_frame), 0);
        chk("async reset start", 32'(start), 0);
        tick();
        tick();
        rst_n = 1'b1;
        s0 = start_tot;
        feed(PIX_N - 200, 0, 1'b0, sl);
        tick();
        chk("post-reset no start", start_tot - s0, 0);
        chk_spec("post-reset spectrum");
        full_line("recovery", 0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/ccd_spectrum_capture.md
# ccd_spectrum_capture

Captures one line of 10-bit CCD pixel samples from the ADC front end and packs them into the 3700-bit `spectrum_values` vector consumed by `UART_TX_Sequence`. It then issues that block's `start` pulse. The block sits directly upstream of the UART transmit sequencer. It skips the sensor's leading dummy pixels, rejects truncated lines, and never overwrites the vector while a transmission is in progress.

## Interface
Parameters:
- `PIX_N`, 370: active pixels per line.
- `PIX_W`, 10: bits per pixel. `PIX_N*PIX_W` must equal 3700.
- `SKIP_N`, 32: dummy pixels discarded after `frame_sync`. 0 is legal.

Ports:
- `clk_50m`, input, 1: system clock, 50 MHz.
- `rst_n`, input, 1: reset, asynchronous, active-low.
- `arm`, input, 1: level; request capture of the next line.
- `tx_busy`, input, 1: high while `UART_TX_Sequence` is transmitting.
- `frame_sync`, input, 1: one-cycle pulse marking the start of a CCD line.
- `adc_valid`, input, 1: one-cycle strobe; `adc_data` is valid this cycle.
- `adc_data`, input, 10: pixel sample.
- `spectrum_values`, output, 3700: packed line. Pixel k occupies `[10k+9:10k]`; pixel 0 is the first active pixel.
- `start`, output, 1: one-cycle pulse when a complete line is in `spectrum_values`.
- `busy`, output, 1: high in states SKIP and CAPTURE.
- `short_frame`, output, 1: sticky error flag. Cleared by reset or by the next successful `start`.

## Operation
- States: IDLE, SKIP, CAPTURE, DONE.
- IDLE: leave when `frame_sync && arm && !tx_busy`.
  - Go to SKIP if `SKIP_N>0`, else go to CAPTURE.
  - The pixel counter clears on entry.
  - A `frame_sync` arriving while `arm` is low or `tx_busy` is high is ignored. No state change.
- SKIP: count `adc_valid` strobes. After the `SKIP_N`-th strobe, go to CAPTURE. Skipped samples are not stored.
- CAPTURE:
  - Each `adc_valid` writes `adc_data` to slice `cnt` and increments `cnt`.
  - On the strobe where `cnt==PIX_N-1`, go to DONE.
  - Other slices hold their values. Slices not yet written in this line keep their previous-line values.
- DONE: assert `start` for exactly one cycle, clear `short_frame`, return to IDLE.
- Truncated line: a `frame_sync` in SKIP or CAPTURE aborts the line.
  - Set `short_frame`.
  - Do not pulse `start`.
  - Return to IDLE the same edge. Do not restart on that same sync pulse; the next sync is required.
- A `tx_busy` rise during SKIP or CAPTURE is ignored. The capture completes. Downstream guarantees `tx_busy` is low whenever the block leaves IDLE.
- `arm` is sampled only in IDLE. Deasserting it mid-capture does not abort the capture.
- `adc_valid` is ignored in IDLE and DONE.
- Counter widths: 9 bits for `cnt` (max 369) and 6 bits for the skip counter (max `SKIP_N-1`). Counters saturate-free; their range is guaranteed by the transitions.

## Timing
- Reset values:
  - state IDLE.
  - `spectrum_values` all zero.
  - `start`, `busy`, `short_frame` all 0.
  - Counters 0.
- All outputs are registered. No combinational path from any input to any output.
- Latency: `start` is asserted on the cycle after the clock edge that captured pixel `PIX_N-1`.
- `spectrum_values` is stable from `start` until the next entry into CAPTURE.
- `busy` rises on the edge leaving IDLE and falls on the edge entering DONE or IDLE.
- `frame_sync` and `adc_valid` in the same cycle during SKIP or CAPTURE: abort wins; the sample is discarded.
- `frame_sync` and `adc_valid` in the same cycle in IDLE: the sample is not counted as a skip pixel.
- Reset mid-capture: immediate return to reset values; any partial line is lost.
- Input rate: `adc_valid` may be asserted every cycle.

## Structure
- Shared package `ccd_pkg`:
  - `PIX_N`, `PIX_W`, `SKIP_N` defaults.
  - The derived constant `SPEC_W = 3700`.
  - The state enumeration.
  - `UART_TX_Sequence` uses the same `SPEC_W`.
- One natural sub-module: `ccd_pixel_counter`, a combined skip/pixel counter with terminal-count flags.
- Slice write uses the indexed part-select `[cnt*PIX_W +: PIX_W]`.

## Test plan
- Nominal line, `SKIP_N=32`: arm=1, sync, then 402 strobes with values 0..401. Required: slice 0 = 32, slice 369 = 401, `start` pulses once, one cycle after the last strobe; `short_frame`=0.
- Back-to-back strobes vs. sparse strobes (every 7th cycle). Required: identical `spectrum_values`; `busy` width scales accordingly.
- Truncated line: sync again after 100 active pixels. Required: no `start`, `short_frame`=1, state IDLE. The following full line yields `start` and clears `short_frame`.
- `tx_busy`=1 at sync. Required: no capture, `spectrum_values` unchanged. Drop `tx_busy` and issue the next sync: capture proceeds.
- arm=0 at sync: ignored. Separately, arm dropped mid-capture: the line still completes with `start`.
- `rst_n` asserted at pixel 200. Required: outputs return to zero asynchronously, and no `start` follows.
